// File: rtl/soc_vga_scanout.sv
// ============================================================================
// soc_vga_scanout
// ----------------------------------------------------------------------------
// VGA scan-out engine for a byte-per-pixel RGB332 framebuffer. It generates
// the raster timing (640x480 @ 60 Hz by default), issues one framebuffer byte
// address per active pixel, and expands each returned RGB332 byte to 4:4:4
// colour pins. All control (sync, blanking, frame marker) is delayed so that
// it reaches the pins together with the colour fetched for the same pixel.
//
// Ports:
//   clk          in   pixel clock, the only clock of the block
//   res          in   synchronous active-high reset
//   enable       in   1 = show framebuffer contents, 0 = force black
//   word_addr_b  out  framebuffer byte address (ADDR_WIDTH bits)
//   read_data_b  in   RGB332 pixel {R[2:0],G[2:0],B[1:0]}, valid FB_LATENCY
//                     cycles after its address
//   vga_r/g/b    out  4-bit colour channels
//   vga_hs       out  horizontal sync (asserted level = HSYNC_POL)
//   vga_vs       out  vertical sync   (asserted level = VSYNC_POL)
//   vblank       out  high while the pins are in vertical blanking
//   frame_start  out  one-cycle pulse with the first active pixel of a frame
//
// Pin latency from the raster counters is FB_LATENCY+1 cycles for every pin.
// ============================================================================
module soc_vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int ADDR_WIDTH = 32,
    parameter int FB_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] word_addr_b,
    input  logic [7:0]            read_data_b,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vblank,
    output logic                  frame_start
);

    // ------------------------------------------------------------------
    // Derived raster geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Control bits that travel alongside the framebuffer read.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic vb;
        logic fs;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL, 1'b0, 1'b0};

    // ------------------------------------------------------------------
    // Raster counters and address counter state
    // ------------------------------------------------------------------
    logic [HW-1:0]         h;
    logic [HW-1:0]         h_next;
    logic [VW-1:0]         v;
    logic [VW-1:0]         v_next;
    logic                  h_wrap;
    logic                  frame_wrap;
    logic                  de_next;
    logic [ADDR_WIDTH-1:0] addr;

    ctrl_t                 stage0;
    ctrl_t                 pipe [FB_LATENCY];
    ctrl_t                 aligned;

    // Next raster position. The vertical counter only moves when the
    // horizontal counter wraps, and both return to zero together at the
    // last position of the frame.
    always_comb begin
        h_wrap     = (h == H_LAST);
        frame_wrap = h_wrap && (v == V_LAST);
        h_next     = h_wrap ? '0 : h + HW'(1);
        v_next     = v;
        if (h_wrap) begin
            v_next = (v == V_LAST) ? '0 : v + VW'(1);
        end
        de_next    = (h_next < H_ACT) && (v_next < V_ACT);
    end

    // Stage-0 decode of the current raster position. Syncs are produced at
    // their asserted polarity here so nothing downstream needs to know it.
    always_comb begin
        stage0.de = (h < H_ACT) && (v < V_ACT);
        stage0.hs = ((h >= HS_START) && (h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        stage0.vs = ((v >= VS_START) && (v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        stage0.vb = (v >= V_ACT);
        stage0.fs = (h == '0) && (v == '0);
    end

    // Raster counters plus the linear pixel address. The address advances
    // as the raster steps into an active pixel, so during active video it
    // is v*H_ACTIVE+h without a multiplier, and through blanking it rests
    // on the last pixel fetched (639 at the end of line 0, 307199 through
    // vertical blanking). The frame wrap clears it for pixel (0,0).
    always_ff @(posedge clk) begin
        if (res) begin
            h    <= '0;
            v    <= '0;
            addr <= '0;
        end else begin
            h <= h_next;
            v <= v_next;
            if (frame_wrap) begin
                addr <= '0;
            end else if (de_next) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign word_addr_b = addr;

    // Control delay line, FB_LATENCY deep, so the decoded control for a
    // pixel arrives in the same cycle as that pixel's read_data_b.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < FB_LATENCY; i++) begin
                pipe[i] <= CTRL_RST;
            end
        end else begin
            pipe[0] <= stage0;
            for (int i = 1; i < FB_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign aligned = pipe[FB_LATENCY-1];

    // Output register: every pin comes from a flop. Colour is expanded by
    // replicating the top bits into the new LSBs so full-scale RGB332 maps
    // to full-scale 4-bit. enable acts here directly rather than travelling
    // down the delay line, so blanking by software takes effect one cycle
    // after it is sampled and never disturbs the syncs.
    always_ff @(posedge clk) begin
        if (res) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= ~HSYNC_POL;
            vga_vs      <= ~VSYNC_POL;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (aligned.de && enable) begin
                vga_r <= {read_data_b[7:5], read_data_b[7]};
                vga_g <= {read_data_b[4:2], read_data_b[4]};
                vga_b <= {read_data_b[1:0], read_data_b[1:0]};
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
            vga_hs      <= aligned.hs;
            vga_vs      <= aligned.vs;
            vblank      <= aligned.vb;
            frame_start <= aligned.fs;
        end
    end

endmodule

// File: tb/tb_soc_vga_scanout.sv
// ============================================================================
// tb_soc_vga_scanout
// ----------------------------------------------------------------------------
// Bench for soc_vga_scanout. Horizontal timing is the full 640-pixel line;
// the frame is shortened to a few lines so whole frames fit in a short run.
// A framebuffer model returns addr[7:0] one cycle after each address. A
// reference raster model pushes the expected pin state of every cycle into a
// queue, which is popped when the DUT pipeline delivers that pixel.
// ============================================================================
module tb_soc_vga_scanout;

    localparam int HA    = 640;
    localparam int HFP   = 16;
    localparam int HS    = 96;
    localparam int HBP   = 48;
    localparam int VA    = 6;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 3;
    localparam int AW    = 32;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int PEAK  = VA * HA - 1;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        vb;
        logic        fs;
        logic [11:0] col;
    } rec_t;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          enable = 1'b1;
    logic [AW-1:0] word_addr_b;
    logic [7:0]    read_data_b = 8'h00;
    logic [3:0]    vga_r;
    logic [3:0]    vga_g;
    logic [3:0]    vga_b;
    logic          vga_hs;
    logic          vga_vs;
    logic          vblank;
    logic          frame_start;

    int   n_checks = 0;
    int   n_pass   = 0;

    logic res_q = 1'b0;
    logic en_s  = 1'b1;
    bit   model_valid = 1'b0;
    int   m_h = 0;
    int   m_v = 0;
    rec_t sb[$];

    soc_vga_scanout #(
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .HSYNC_POL  (1'b0),
        .VSYNC_POL  (1'b0),
        .ADDR_WIDTH (AW),
        .FB_LATENCY (1)
    ) dut (
        .clk         (clk),
        .res         (res),
        .enable      (enable),
        .word_addr_b (word_addr_b),
        .read_data_b (read_data_b),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer model: one-cycle read latency, data = low address byte.
    always @(posedge clk) begin
        read_data_b <= word_addr_b[7:0];
    end

    // What the DUT saw at each active edge.
    always @(posedge clk) begin
        res_q <= res;
        en_s  <= enable;
    end

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    // Address the reference raster expects in a given position.
    function automatic int exp_addr(input int h, input int v);
        if (v >= VA) return PEAK;
        if (h >= HA) return v * HA + HA - 1;
        return v * HA + h;
    endfunction

    function automatic rec_t mk_rec(input int h, input int v);
        rec_t r;
        int   a;
        logic [31:0] a32;
        a     = exp_addr(h, v);
        a32   = a;
        r.de  = (h < HA) && (v < VA);
        r.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
        r.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
        r.vb  = (v >= VA);
        r.fs  = (h == 0) && (v == 0);
        r.col = expand(a32[7:0]);
        return r;
    endfunction

    // Scoreboard: push the expected pin state of the current raster
    // position, pop the one the DUT pipeline is delivering now.
    always @(negedge clk) begin
        rec_t        e;
        logic [15:0] want;
        logic [15:0] got;
        int          a;
        got = {vga_hs, vga_vs, vblank, frame_start, vga_r, vga_g, vga_b};
        if (res_q) begin
            m_h = 0;
            m_v = 0;
            model_valid = 1'b1;
            sb.delete();
            e = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
            sb.push_back(e);
            sb.push_back(mk_rec(0, 0));
            want = 16'hC000;
            a    = 0;
        end else if (model_valid) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            sb.push_back(mk_rec(m_h, m_v));
            e    = sb.pop_front();
            want = {e.hs, e.vs, e.vb, e.fs, (e.de && en_s) ? e.col : 12'h000};
            a    = exp_addr(m_h, m_v);
        end
        if (model_valid) begin
            n_checks++;
            if (got !== want) begin
                $display("[TB] FAIL sb_pins at h=%0d v=%0d: got %h, want %h", m_h, m_v, got, want);
            end else begin
                n_pass++;
            end
            n_checks++;
            if (word_addr_b !== AW'(a)) begin
                $display("[TB] FAIL sb_addr at h=%0d v=%0d: got %0d, want %0d", m_h, m_v, word_addr_b, a);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, word_addr_b} !== {12'h000, 1'b1, 1'b1, AW'(0)}) begin
                $display("[TB] FAIL reset_pins cycle %0d: rgb=%h hs=%b vs=%b addr=%0d, want rgb=000 hs=1 vs=1 addr=0",
                         i, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, word_addr_b);
            end else begin
                n_pass++;
            end
        end
        res = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (word_addr_b !== AW'(k)) begin
                $display("[TB] FAIL reset_addr_seq: got %0d, want %0d", word_addr_b, k);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_pixel_alignment();
        logic [7:0]    target [2];
        logic [11:0]   want   [2];
        logic [AW-1:0] prev;
        bit            found;
        target[0] = 8'h92;  want[0] = 12'h99A;
        target[1] = 8'hE3;  want[1] = 12'hF0F;
        for (int t = 0; t < 2; t++) begin
            found = 1'b0;
            prev  = '0;
            for (int i = 0; i < HT && !found; i++) begin
                @(negedge clk);
                if (word_addr_b == AW'(target[t])) found = 1'b1;
                else prev = word_addr_b;
            end
            n_checks++;
            if (!found) begin
                $display("[TB] FAIL align_wait: address %h not issued within %0d cycles", target[t], HT);
            end else begin
                n_pass++;
                @(negedge clk);
                n_checks++;
                if ({vga_r, vga_g, vga_b} !== expand(prev[7:0])) begin
                    $display("[TB] FAIL align_early for %h: got %h, want %h", target[t], {vga_r, vga_g, vga_b}, expand(prev[7:0]));
                end else begin
                    n_pass++;
                end
                @(negedge clk);
                n_checks++;
                if ({vga_r, vga_g, vga_b} !== want[t]) begin
                    $display("[TB] FAIL align_pix for %h: got %h, want %h", target[t], {vga_r, vga_g, vga_b}, want[t]);
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    task automatic test_h_timing();
        bit            found;
        int            hold;
        int            hs_first;
        int            hs_low;
        bit            changed;
        logic [AW-1:0] next_a;
        found = 1'b0;
        for (int i = 0; i < HT && !found; i++) begin
            @(negedge clk);
            if (word_addr_b == AW'(HA - 1)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("[TB] FAIL htime_wait: address %0d not seen", HA - 1);
        end else begin
            n_pass++;
            hold = 1; hs_first = -1; hs_low = 0; changed = 1'b0; next_a = '0;
            for (int i = 1; i <= 170; i++) begin
                @(negedge clk);
                if (!changed) begin
                    if (word_addr_b == AW'(HA - 1)) hold++;
                    else begin changed = 1'b1; next_a = word_addr_b; end
                end
                if (!vga_hs) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = i;
                end
            end
            n_checks++;
            if (hold !== HT - HA + 1) $display("[TB] FAIL htime_hold: %0d cycles at %0d, want %0d", hold, HA - 1, HT - HA + 1);
            else n_pass++;
            n_checks++;
            if (next_a !== AW'(HA)) $display("[TB] FAIL htime_line1: got %0d, want %0d", next_a, HA);
            else n_pass++;
            n_checks++;
            if (hs_first !== HFP + 1 + 2) $display("[TB] FAIL htime_hs_start: offset %0d, want %0d", hs_first, HFP + 3);
            else n_pass++;
            n_checks++;
            if (hs_low !== HS) $display("[TB] FAIL htime_hs_width: got %0d, want %0d", hs_low, HS);
            else n_pass++;
        end
    endtask

    task automatic test_frame_wrap();
        int            max_a, wraps, fs_n, fs_first, fs_second;
        int            vs_cnt, vs_run, vb_cnt, vb_run;
        bit            vs_seen_hi, vb_seen_lo;
        logic [AW-1:0] prev_a;
        max_a = 0; wraps = 0; fs_n = 0; fs_first = -1; fs_second = -1;
        vs_cnt = 0; vs_run = -1; vb_cnt = 0; vb_run = -1;
        vs_seen_hi = 1'b0; vb_seen_lo = 1'b0; prev_a = '0;
        for (int i = 0; i < 2 * FRAME + 200; i++) begin
            @(negedge clk);
            if (int'(word_addr_b) > max_a) max_a = int'(word_addr_b);
            if (i > 0 && prev_a == AW'(PEAK) && word_addr_b == '0) wraps++;
            prev_a = word_addr_b;
            if (frame_start) begin
                fs_n++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (vga_vs) begin
                if (vs_cnt > 0 && vs_run < 0) vs_run = vs_cnt;
                vs_cnt = 0; vs_seen_hi = 1'b1;
            end else if (vs_seen_hi) vs_cnt++;
            if (!vblank) begin
                if (vb_cnt > 0 && vb_run < 0) vb_run = vb_cnt;
                vb_cnt = 0; vb_seen_lo = 1'b1;
            end else if (vb_seen_lo) vb_cnt++;
        end
        n_checks++;
        if (max_a !== PEAK) $display("[TB] FAIL frame_peak: got %0d, want %0d", max_a, PEAK);
        else n_pass++;
        n_checks++;
        if (wraps !== 2) $display("[TB] FAIL frame_addr_wrap: got %0d wraps, want 2", wraps);
        else n_pass++;
        n_checks++;
        if (fs_n !== 2) $display("[TB] FAIL frame_start_count: got %0d, want 2", fs_n);
        else n_pass++;
        n_checks++;
        if (fs_second - fs_first !== FRAME) $display("[TB] FAIL frame_start_period: got %0d, want %0d", fs_second - fs_first, FRAME);
        else n_pass++;
        n_checks++;
        if (vs_run !== VS * HT) $display("[TB] FAIL frame_vs_width: got %0d, want %0d", vs_run, VS * HT);
        else n_pass++;
        n_checks++;
        if (vb_run !== (VT - VA) * HT) $display("[TB] FAIL frame_vblank_width: got %0d, want %0d", vb_run, (VT - VA) * HT);
        else n_pass++;
    endtask

    task automatic test_enable();
        bit            found;
        int            nz, hs_lo;
        logic [AW-1:0] last_a;
        found = 1'b0;
        for (int i = 0; i < FRAME + HT && !found; i++) begin
            @(negedge clk);
            if (word_addr_b == AW'(2 * HA + 600)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("[TB] FAIL enable_wait: address %0d not seen", 2 * HA + 600);
        end else begin
            n_pass++;
            @(posedge clk); #2 enable = 1'b0;
            nz = 0; hs_lo = 0; last_a = '0;
            for (int i = 1; i <= 250; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    n_checks++;
                    if (word_addr_b !== AW'(2 * HA + 601)) $display("[TB] FAIL enable_addr_next: got %0d, want %0d", word_addr_b, 2 * HA + 601);
                    else n_pass++;
                end
                if (i >= 2 && {vga_r, vga_g, vga_b} != 12'h000) nz++;
                if (!vga_hs) hs_lo++;
                last_a = word_addr_b;
            end
            n_checks++;
            if (nz !== 0) $display("[TB] FAIL enable_black: %0d non-black cycles, want 0", nz);
            else n_pass++;
            n_checks++;
            if (hs_lo !== HS) $display("[TB] FAIL enable_hsync: got %0d low cycles, want %0d", hs_lo, HS);
            else n_pass++;
            n_checks++;
            if (last_a !== AW'(3 * HA + 50)) $display("[TB] FAIL enable_addr_seq: got %0d, want %0d", last_a, 3 * HA + 50);
            else n_pass++;
            @(posedge clk); #2 enable = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({vga_r, vga_g, vga_b} !== 12'h000) $display("[TB] FAIL enable_still_black: got %h, want 000", {vga_r, vga_g, vga_b});
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({vga_r, vga_g, vga_b} !== expand(last_a[7:0])) $display("[TB] FAIL enable_restore: got %h, want %h", {vga_r, vga_g, vga_b}, expand(last_a[7:0]));
            else n_pass++;
        end
    endtask

    task automatic test_mid_frame_reset();
        bit found;
        int hs_at;
        found = 1'b0;
        for (int i = 0; i < FRAME + HT && !found; i++) begin
            @(negedge clk);
            if (word_addr_b == AW'(4 * HA + 300)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("[TB] FAIL midreset_wait: address %0d not seen", 4 * HA + 300);
        end else begin
            n_pass++;
            @(posedge clk); #2 res = 1'b1;
            @(posedge clk); #2 res = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({word_addr_b, vga_r, vga_g, vga_b, vga_hs} !== {AW'(0), 12'h000, 1'b1})
                $display("[TB] FAIL midreset_first: addr=%0d rgb=%h hs=%b, want addr=0 rgb=000 hs=1",
                         word_addr_b, {vga_r, vga_g, vga_b}, vga_hs);
            else n_pass++;
            hs_at = -1;
            for (int j = 1; j <= HT && hs_at < 0; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    n_checks++;
                    if (word_addr_b !== AW'(1)) $display("[TB] FAIL midreset_addr1: got %0d, want 1", word_addr_b);
                    else n_pass++;
                end
                if (!vga_hs) hs_at = j;
            end
            n_checks++;
            if (hs_at !== HA + HFP + 2) $display("[TB] FAIL midreset_hsync: edge after %0d cycles, want %0d", hs_at, HA + HFP + 2);
            else n_pass++;
        end
    endtask

    initial begin
        #(90000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting soc_vga_scanout bench");
        test_reset();
        test_pixel_alignment();
        test_h_timing();
        test_frame_wrap();
        test_enable();
        test_mid_frame_reset();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
